dpbram_xfer_seq: RTL and testbench
==================================

// Module: dpbram_xfer_seq
// PURPOSE
//  Parametrised DSP<->PL dual-port BRAM transfer sequencer, next-generation DSP external-interface engine.
//  On DSP interrupt: writes a PS-side block into the DPBRAM, waits a fixed window for DSP access,
//  then reads back a DSP-side block. Each word is streamed out with an index strobe, so parent
//  modules decode and capture registers.
//  Sits between the DSP interrupt/DPBRAM port and the EPICS/PS register banks.
// PARAMETERS
//  ADDR_W     9     DPBRAM address width
//  DATA_W     16    DPBRAM data width
//  WR_BASE    124   first write address
//  WR_LEN     26    words written per cycle (>=1)
//  RD_BASE    0     first read address
//  RD_LEN     125   words read per cycle (>=1)
//  DELAY_CNT  1458  DELAY state length in clocks (>=1)
//  WAIT_CYC   2     clocks per word slot (>=2; RAM read latency must be <= WAIT_CYC-1)
//  CNT_W      16    width of o_drop_cnt
// PORTS
//  i_clk        in   1       system clock
//  i_rst        in   1       reset, synchronous, active-high
//  i_en         in   1       1 = accept interrupts in IDLE
//  i_DSP_intr   in   1       DSP interrupt, level
//  o_wr_idx     out  ADDR_W  current write word index (0..WR_LEN-1)
//  i_wr_word    in   DATA_W  write data for o_wr_idx, supplied combinationally by parent
//  o_ram_addr   out  ADDR_W  DPBRAM address
//  o_ram_ce     out  1       DPBRAM enable
//  o_ram_we     out  1       DPBRAM write enable
//  o_ram_din    out  DATA_W  DPBRAM write data
//  i_ram_dout   in   DATA_W  DPBRAM read data
//  o_rd_valid   out  1       1-clk strobe: o_rd_idx/o_rd_data valid
//  o_rd_idx     out  ADDR_W  read word index (0..RD_LEN-1)
//  o_rd_data    out  DATA_W  read word
//  o_delay_end  out  1       1-clk pulse on last DELAY clock (waveform counter tick)
//  o_done       out  1       1-clk pulse on READ->DONE
//  o_busy       out  1       state is WRITE, DELAY or READ
//  o_drop_cnt   out  CNT_W   count of premature interrupt drops, saturating
//  o_fsm_state  out  3       state encoding (debug)
// BEHAVIOUR
//  - States: IDLE=0, WRITE=1, DELAY=2, READ=3, DONE=4. Undefined encodings go to IDLE.
//  - Reset: all outputs 0 except o_ram_addr = WR_BASE; state IDLE; o_drop_cnt = 0.
//    A reset mid-sequence drops ce/we on the next edge.
//  - IDLE: i_en & i_DSP_intr -> WRITE. Otherwise hold; o_ram_addr = WR_BASE.
//  - Word slot: WAIT_CYC clocks. Address, ce and we are held constant for the whole slot.
//    A phase counter runs 0..WAIT_CYC-1.
//  - WRITE: ce=we=1; o_ram_addr = WR_BASE+o_wr_idx; o_ram_din = i_wr_word (combinational, 0 when we=0).
//    Index advances at phase WAIT_CYC-1. After the last slot -> DELAY.
//    Duration is exactly WR_LEN*WAIT_CYC clocks.
//  - DELAY: ce=we=0. A counter runs 0..DELAY_CNT-1; o_delay_end pulses at DELAY_CNT-1, then -> READ.
//    The first READ address is presented at the DELAY->READ edge.
//  - READ: ce=1, we=0; o_ram_addr = RD_BASE+idx. At phase WAIT_CYC-1, i_ram_dout is registered
//    into o_rd_data and idx into o_rd_idx; o_rd_valid pulses on the following clock.
//    After the last slot -> DONE; o_done pulses in the first DONE clock, coincident with the final o_rd_valid.
//  - DONE: ce=we=0; wait for ~i_DSP_intr -> IDLE. A held interrupt never restarts the sequence.
//  - Interrupt drop: i_DSP_intr low in any WRITE/DELAY/READ clock, at the first such clock per sequence,
//    increments o_drop_cnt by 1 (saturates at all-ones). The sequence still completes;
//    DONE then exits on the next clock.
//  - i_en low only blocks IDLE->WRITE; a sequence in flight completes.
//  - Address arithmetic: modulo 2^ADDR_W. Wrap past the top is permitted and not flagged.
//  - Total busy time = (WR_LEN+RD_LEN)*WAIT_CYC + DELAY_CNT clocks.
//    Defaults: 52+1458+250 = 1760 clocks.
// TESTING (bench: WR_LEN=4, RD_LEN=3, DELAY_CNT=5, WAIT_CYC=2, WR_BASE=10, RD_BASE=0 unless stated)
//  T1 Basic cycle: raise intr, i_wr_word=16'hA000+o_wr_idx, RAM preloaded {1,2,3}.
//     -> writes A000..A003 at addr 10..13 (2 clk each); delay_end after 5 clk;
//     -> rd_valid x3 with data 1,2,3, idx 0,1,2; done; busy exactly 19 clk.
//  T2 Held interrupt: keep intr high 100 clk after done -> stays DONE, no second sequence.
//     Drop intr -> IDLE. Re-raise -> new sequence.
//  T3 Premature drop: deassert intr in DELAY, reassert in READ -> o_drop_cnt=1 (not 2).
//     Sequence completes; DONE exits immediately.
//  T4 Reset mid-READ: assert i_rst for 1 clk -> next edge ce=we=0, state IDLE, addr=10, drop_cnt=0.
//  T5 Enable gating: i_en=0 with intr high -> stays IDLE. Set i_en=1 -> WRITE on next edge.
//  T6 Defaults build, WAIT_CYC=3: busy = 1458+(26+125)*3 = 1911 clk.
//     Read data sampled at phase 2; o_drop_cnt saturation forced with CNT_W=2 -> holds 3.

Source files
------------

// File: rtl/dpbram_xfer_seq.sv
// DSP<->PL dual-port BRAM transfer sequencer: on DSP interrupt, write a block, wait a
// fixed window for DSP access, read a block back and stream every word out with its index.
module dpbram_xfer_seq #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 16,
    parameter int WR_BASE   = 124,
    parameter int WR_LEN    = 26,
    parameter int RD_BASE   = 0,
    parameter int RD_LEN    = 125,
    parameter int DELAY_CNT = 1458,
    parameter int WAIT_CYC  = 2,
    parameter int CNT_W     = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_DSP_intr,
    output logic [ADDR_W-1:0] o_wr_idx,
    input  logic [DATA_W-1:0] i_wr_word,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_ce,
    output logic              o_ram_we,
    output logic [DATA_W-1:0] o_ram_din,
    input  logic [DATA_W-1:0] i_ram_dout,
    output logic              o_rd_valid,
    output logic [ADDR_W-1:0] o_rd_idx,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_delay_end,
    output logic              o_done,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_drop_cnt,
    output logic [2:0]        o_fsm_state
);

    localparam int PH_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam int DC_W = $clog2(DELAY_CNT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_DELAY = 3'd2,
        S_READ  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [PH_W-1:0]   phase;
    logic [ADDR_W-1:0] idx;
    logic [DC_W-1:0]   dcnt;
    logic              dropped;
    logic              slot_end, slot_st, dly_last;

    assign slot_st  = (state == S_WRITE) || (state == S_READ);
    assign slot_end = slot_st && (phase == PH_W'(WAIT_CYC - 1));
    assign dly_last = (state == S_DELAY) && (dcnt == DC_W'(DELAY_CNT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_en && i_DSP_intr) state_nxt = S_WRITE;
            S_WRITE: if (slot_end && idx == ADDR_W'(WR_LEN - 1)) state_nxt = S_DELAY;
            S_DELAY: if (dly_last) state_nxt = S_READ;
            S_READ:  if (slot_end && idx == ADDR_W'(RD_LEN - 1)) state_nxt = S_DONE;
            // A drop already seen this sequence releases DONE even if the interrupt came back.
            S_DONE:  if (!i_DSP_intr || dropped) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // RAM controls decode straight from registered state, so a new slot's address
    // appears on the same edge that starts it.
    always_comb begin
        o_busy      = (state == S_WRITE) || (state == S_DELAY) || (state == S_READ);
        o_ram_ce    = slot_st;
        o_ram_we    = (state == S_WRITE);
        o_ram_addr  = ((state == S_READ) ? ADDR_W'(RD_BASE) : ADDR_W'(WR_BASE))
                    + (slot_st ? idx : '0);
        o_wr_idx    = (state == S_WRITE) ? idx : '0;
        o_ram_din   = o_ram_we ? i_wr_word : '0;
        o_delay_end = dly_last;
        o_fsm_state = state;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_IDLE;
            phase      <= '0;
            idx        <= '0;
            dcnt       <= '0;
            dropped    <= 1'b0;
            o_drop_cnt <= '0;
            o_rd_valid <= 1'b0;
            o_rd_idx   <= '0;
            o_rd_data  <= '0;
            o_done     <= 1'b0;
        end else begin
            state      <= state_nxt;
            o_rd_valid <= 1'b0;
            o_done     <= 1'b0;

            if (slot_st) phase <= slot_end ? '0 : phase + PH_W'(1);
            else         phase <= '0;

            if (!slot_st)     idx <= '0;
            else if (slot_end) idx <= (state_nxt != state) ? '0 : idx + ADDR_W'(1);

            dcnt <= ((state == S_DELAY) && !dly_last) ? dcnt + DC_W'(1) : '0;

            if (state == S_READ && slot_end) begin
                o_rd_data  <= i_ram_dout;
                o_rd_idx   <= idx;
                o_rd_valid <= 1'b1;
            end
            if (state == S_READ && state_nxt == S_DONE) o_done <= 1'b1;

            if (state == S_IDLE) begin
                dropped <= 1'b0;
            end else if (o_busy && !i_DSP_intr && !dropped) begin
                dropped <= 1'b1;
                if (o_drop_cnt != '1) o_drop_cnt <= o_drop_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dpbram_xfer_seq.sv
// Directed bench for dpbram_xfer_seq: a small-parameter instance for sequencing corner
// cases and a defaults-sized instance (WAIT_CYC=3, CNT_W=2) for timing and saturation.
module tb_dpbram_xfer_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en, intr, en2, intr2;

    logic [8:0]  wr_idx1, addr1, rdi1;
    logic [15:0] wr_word1, din1, dout1, rdd1, drop1;
    logic        ce1, we1, rv1, de1, done1, busy1;
    logic [2:0]  st1;

    logic [8:0]  wr_idx2, addr2, rdi2;
    logic [15:0] wr_word2, din2, dout2, r2a, rdd2;
    logic [1:0]  drop2;
    logic        ce2, we2, rv2, de2, done2, busy2;
    logic [2:0]  st2;

    assign wr_word1 = 16'hA000 + {7'd0, wr_idx1};
    assign wr_word2 = 16'h5000 + 16'd124 + {7'd0, wr_idx2};

    dpbram_xfer_seq #(.ADDR_W(9), .DATA_W(16), .WR_BASE(10), .WR_LEN(4), .RD_BASE(0),
                      .RD_LEN(3), .DELAY_CNT(5), .WAIT_CYC(2), .CNT_W(16)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_DSP_intr(intr),
        .o_wr_idx(wr_idx1), .i_wr_word(wr_word1),
        .o_ram_addr(addr1), .o_ram_ce(ce1), .o_ram_we(we1), .o_ram_din(din1),
        .i_ram_dout(dout1), .o_rd_valid(rv1), .o_rd_idx(rdi1), .o_rd_data(rdd1),
        .o_delay_end(de1), .o_done(done1), .o_busy(busy1), .o_drop_cnt(drop1),
        .o_fsm_state(st1));

    dpbram_xfer_seq #(.WAIT_CYC(3), .CNT_W(2)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_en(en2), .i_DSP_intr(intr2),
        .o_wr_idx(wr_idx2), .i_wr_word(wr_word2),
        .o_ram_addr(addr2), .o_ram_ce(ce2), .o_ram_we(we2), .o_ram_din(din2),
        .i_ram_dout(dout2), .o_rd_valid(rv2), .o_rd_idx(rdi2), .o_rd_data(rdd2),
        .o_delay_end(de2), .o_done(done2), .o_busy(busy2), .o_drop_cnt(drop2),
        .o_fsm_state(st2));

    // RAM 1: one-clock read latency, {1,2,3} at addresses 0..2.
    logic [15:0] mem1 [512];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 512; i++) mem1[i] <= (i < 3) ? 16'(i + 1) : 16'h0;
            dout1 <= 16'h0;
        end else if (ce1) begin
            if (we1) mem1[addr1] <= din1;
            dout1 <= mem1[addr1];
        end
    end

    // RAM 2: two-clock read latency, mem[a] = 5000h + a (writes keep that invariant).
    logic [15:0] mem2 [512];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 512; i++) mem2[i] <= 16'h5000 + 16'(i);
            r2a   <= 16'h0;
            dout2 <= 16'h0;
        end else begin
            if (ce2) begin
                if (we2) mem2[addr2] <= din2;
                r2a <= mem2[addr2];
            end
            dout2 <= r2a;
        end
    end

    int bcnt1 = 0, wcnt1 = 0, de_at1 = 0, rvn1 = 0, bcnt2 = 0, rvn2 = 0, rvbad2 = 0;
    logic dwr1 = 1'b0;
    logic [15:0] rvd1 [64];
    logic [8:0]  rvi1 [64];

    always @(negedge clk) begin
        if (busy1) bcnt1 <= bcnt1 + 1;
        if (we1)   wcnt1 <= wcnt1 + 1;
        if (de1)   de_at1 <= bcnt1;
        if (done1) dwr1 <= rv1;
        if (rv1) begin
            rvd1[rvn1 % 64] <= rdd1;
            rvi1[rvn1 % 64] <= rdi1;
            rvn1 <= rvn1 + 1;
        end
        if (busy2) bcnt2 <= bcnt2 + 1;
        if (rv2) begin
            rvn2 <= rvn2 + 1;
            if (rdd2 !== 16'h5000 + {7'd0, rdi2}) rvbad2 <= rvbad2 + 1;
        end
    end

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_st(input string tag, input bit d2, input logic [2:0] s, input int maxc);
        int n = 0;
        while ((d2 ? st2 : st1) != s && n < maxc) begin
            tick();
            n++;
        end
        chk(tag, d2 ? st2 : st1, s);
    endtask

    int bb, rb, b2, r2;

    initial begin
        rst = 1'b1; en = 1'b1; intr = 1'b0; en2 = 1'b1; intr2 = 1'b0;
        tick(); tick();
        chk("rst_state", st1, 0);
        chk("rst_addr", addr1, 10);
        chk("rst_cewe", {ce1, we1, busy1, rv1, done1, de1}, 0);
        chk("rst_drop", drop1, 0);
        rst = 1'b0;
        tick();

        // T1 basic cycle
        bb = bcnt1; rb = rvn1;
        intr = 1'b1;
        wait_st("t1_done", 0, 3'd4, 100);
        tick();
        chk("t1_busy", bcnt1 - bb, 19);
        chk("t1_we", wcnt1, 8);
        for (int k = 0; k < 4; k++) chk("t1_mem", mem1[10 + k], 16'hA000 + 16'(k));
        chk("t1_delay_end", de_at1 - bb, 12);
        chk("t1_rvn", rvn1 - rb, 3);
        for (int k = 0; k < 3; k++) begin
            chk("t1_rdata", rvd1[(rb + k) % 64], k + 1);
            chk("t1_ridx", rvi1[(rb + k) % 64], k);
        end
        chk("t1_done_rv", dwr1, 1);

        // T2 held interrupt
        repeat (100) tick();
        chk("t2_hold", st1, 4);
        chk("t2_nobusy", bcnt1 - bb, 19);
        intr = 1'b0;
        tick();
        chk("t2_idle", st1, 0);
        chk("t2_nodrop", drop1, 0);
        intr = 1'b1;
        tick();
        chk("t2_restart", st1, 1);
        wait_st("t2_done", 0, 3'd4, 100);
        intr = 1'b0;
        tick();
        chk("t2_idle2", st1, 0);

        // T3 premature drop
        intr = 1'b1;
        wait_st("t3_delay", 0, 3'd2, 50);
        intr = 1'b0;
        wait_st("t3_read", 0, 3'd3, 50);
        intr = 1'b1;
        wait_st("t3_done", 0, 3'd4, 50);
        chk("t3_drop", drop1, 1);
        tick();
        chk("t3_exit", st1, 0);
        intr = 1'b0;
        tick();
        chk("t3_idle", st1, 0);

        // T4 reset mid-READ
        intr = 1'b1;
        wait_st("t4_read", 0, 3'd3, 50);
        rst = 1'b1;
        tick();
        chk("t4_cewe", {ce1, we1}, 0);
        chk("t4_state", st1, 0);
        chk("t4_addr", addr1, 10);
        chk("t4_drop", drop1, 0);
        rst = 1'b0; intr = 1'b0;
        tick();

        // T5 enable gating
        en = 1'b0; intr = 1'b1;
        repeat (5) tick();
        chk("t5_gated", st1, 0);
        en = 1'b1;
        tick();
        chk("t5_start", st1, 1);
        intr = 1'b0;
        wait_st("t5_done", 0, 3'd4, 50);
        tick();
        chk("t5_idle", st1, 0);
        chk("t5_drop", drop1, 1);

        // T6 default geometry, WAIT_CYC=3
        b2 = bcnt2; r2 = rvn2;
        intr2 = 1'b1;
        wait_st("t6_done", 1, 3'd4, 3000);
        tick();
        chk("t6_busy", bcnt2 - b2, 1911);
        chk("t6_rvn", rvn2 - r2, 125);
        chk("t6_rdata", rvbad2, 0);
        chk("t6_nodrop", drop2, 0);
        intr2 = 1'b0;
        tick();
        chk("t6_idle", st2, 0);
        for (int k = 1; k <= 4; k++) begin
            intr2 = 1'b1;
            tick();
            intr2 = 1'b0;
            wait_st("t6_sat_done", 1, 3'd4, 3000);
            tick();
            chk("t6_sat", drop2, (k > 3) ? 3 : k);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
